// File: rtl/up_bus_arbiter_pkg.sv
// Shared types and constants for the up_* register bus arbiter.
package up_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Ring order of request sources; bit 0 = read, bit 1 = requester index.
  typedef enum logic [1:0] {
    SRC_M0_W = 2'd0,
    SRC_M0_R = 2'd1,
    SRC_M1_W = 2'd2,
    SRC_M1_R = 2'd3
  } src_e;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_DEAD;

  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/up_rr_pick4.sv
// Four-way round-robin picker: first eligible source after 'last' in ring order.
module up_rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] last,
  output logic [1:0] grant_c,
  output logic       valid_c
);

  logic [1:0] idx;

  // Walk from farthest to nearest so the nearest eligible source wins.
  always_comb begin
    grant_c = last;
    valid_c = 1'b0;
    idx     = last;
    for (int off = 4; off >= 1; off--) begin
      idx = 2'(int'(last) + off);
      if (eligible[idx]) begin
        grant_c = idx;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/up_bus_arbiter.sv
// Two-requester round-robin arbiter for the up_* register bus with slave-ack timeout.
module up_bus_arbiter
  import up_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic                  m0_wreq,
  input  logic [ADDR_WIDTH-1:0] m0_waddr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_wack,
  input  logic                  m0_rreq,
  input  logic [ADDR_WIDTH-1:0] m0_raddr,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_rack,
  input  logic                  m1_wreq,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_wack,
  input  logic                  m1_rreq,
  input  logic [ADDR_WIDTH-1:0] m1_raddr,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_rack,
  output logic                  s_wreq,
  output logic [ADDR_WIDTH-1:0] s_waddr,
  output logic [DATA_W-1:0]     s_wdata,
  input  logic                  s_wack,
  output logic                  s_rreq,
  output logic [ADDR_WIDTH-1:0] s_raddr,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic                  s_rack,
  output logic [1:0]            up_timeout_err,
  input  logic                  up_err_clr
);

  localparam int unsigned CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned NSRC  = 4;

  logic [NSRC-1:0]       pulse, pend_q, elig, clr_c;
  logic [ADDR_WIDTH-1:0] in_addr [NSRC];
  logic [ADDR_WIDTH-1:0] addr_q  [NSRC];
  logic [DATA_W-1:0]     in_data [2];
  logic [DATA_W-1:0]     data_q  [2];

  arb_state_e            state_q, state_d;
  logic [1:0]            grant_q, grant_d, last_q, last_d, pick_c;
  logic                  pick_valid_c, ack_match_c, expired_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] sel_addr_c, s_waddr_d, s_raddr_d;
  logic [DATA_W-1:0]     sel_data_c, s_wdata_d, rdata0_d, rdata1_d;
  logic                  s_wreq_d, s_rreq_d;
  logic [1:0]            wack_d, rack_d, err_set_c;

  assign pulse      = {m1_rreq, m1_wreq, m0_rreq, m0_wreq};
  assign in_addr[0] = m0_waddr;
  assign in_addr[1] = m0_raddr;
  assign in_addr[2] = m1_waddr;
  assign in_addr[3] = m1_raddr;
  assign in_data[0] = m0_wdata;
  assign in_data[1] = m1_wdata;

  assign elig  = pend_q | pulse;
  assign clr_c = (state_q == RESP) ? (NSRC'(1) << grant_q) : '0;

  // Same-cycle pulses bypass the capture registers so an idle bus grants immediately.
  assign sel_addr_c  = pend_q[pick_c] ? addr_q[pick_c]    : in_addr[pick_c];
  assign sel_data_c  = pend_q[pick_c] ? data_q[pick_c[1]] : in_data[pick_c[1]];
  assign ack_match_c = grant_q[0] ? s_rack : s_wack;
  assign expired_c   = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  up_rr_pick4 u_pick (
    .eligible (elig),
    .last     (last_q),
    .grant_c  (pick_c),
    .valid_c  (pick_valid_c)
  );

  // Request capture; a repeat pulse on a pending source keeps the first payload.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      pend_q <= '0;
      for (int i = 0; i < NSRC; i++) addr_q[i] <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      pend_q <= (pend_q | pulse) & ~clr_c;
      for (int i = 0; i < NSRC; i++) begin
        if (pulse[i] && !pend_q[i]) addr_q[i] <= in_addr[i];
      end
      if (m0_wreq && !pend_q[0]) data_q[0] <= m0_wdata;
      if (m1_wreq && !pend_q[2]) data_q[1] <= m1_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_wreq_d  = 1'b0;
    s_rreq_d  = 1'b0;
    s_waddr_d = s_waddr;
    s_raddr_d = s_raddr;
    s_wdata_d = s_wdata;
    wack_d    = 2'b00;
    rack_d    = 2'b00;
    rdata0_d  = m0_rdata;
    rdata1_d  = m1_rdata;
    err_set_c = 2'b00;
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          grant_d = pick_c;
          cnt_d   = '0;
          state_d = BUSY;
          if (pick_c[0]) begin
            s_rreq_d  = 1'b1;
            s_raddr_d = sel_addr_c;
          end else begin
            s_wreq_d  = 1'b1;
            s_waddr_d = sel_addr_c;
            s_wdata_d = sel_data_c;
          end
        end
      end
      BUSY: begin
        // A matching ack on the expiry cycle still counts as a normal completion.
        if (ack_match_c || expired_c) begin
          state_d = RESP;
          if (grant_q[0]) begin
            rack_d[grant_q[1]] = 1'b1;
            if (grant_q[1]) rdata1_d = ack_match_c ? s_rdata : ERR_DATA;
            else            rdata0_d = ack_match_c ? s_rdata : ERR_DATA;
          end else begin
            wack_d[grant_q[1]] = 1'b1;
          end
          if (!ack_match_c) err_set_c[grant_q[1]] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_q         <= SRC_M1_R;
      cnt_q          <= '0;
      s_wreq         <= 1'b0;
      s_rreq         <= 1'b0;
      s_waddr        <= '0;
      s_raddr        <= '0;
      s_wdata        <= '0;
      m0_wack        <= 1'b0;
      m0_rack        <= 1'b0;
      m1_wack        <= 1'b0;
      m1_rack        <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      up_timeout_err <= 2'b00;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      s_wreq         <= s_wreq_d;
      s_rreq         <= s_rreq_d;
      s_waddr        <= s_waddr_d;
      s_raddr        <= s_raddr_d;
      s_wdata        <= s_wdata_d;
      m0_wack        <= wack_d[0];
      m0_rack        <= rack_d[0];
      m1_wack        <= wack_d[1];
      m1_rack        <= rack_d[1];
      m0_rdata       <= rdata0_d;
      m1_rdata       <= rdata1_d;
      up_timeout_err <= up_err_clr ? 2'b00 : (up_timeout_err | err_set_c);
    end
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Directed bench for up_bus_arbiter with a slave model and per-requester ack scoreboard.
module tb_up_bus_arbiter;

  localparam int unsigned AW   = 14;
  localparam int unsigned TMO  = 64;
  localparam logic [31:0] ERRD = 32'hDEAD_DEAD;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  typedef struct {
    logic        rd;
    logic [13:0] addr;
    logic [31:0] data;
    int          cyc;
  } gl_t;

  logic          up_clk = 1'b0;
  logic          up_rstn;
  logic          m0_wreq, m0_rreq, m1_wreq, m1_rreq;
  logic [AW-1:0] m0_waddr, m0_raddr, m1_waddr, m1_raddr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_wack, m0_rack, m1_wack, m1_rack;
  logic          s_wreq, s_rreq, s_wack, s_rack;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [31:0]   s_wdata, s_rdata;
  logic [1:0]    up_timeout_err;
  logic          up_err_clr;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  frc_wack_cyc = -1;
  int  frc_rack_cyc = -1;
  int  slv_delay = 1;
  int  slv_cnt = 0;
  logic          slv_rd = 1'b0;
  logic [AW-1:0] slv_addr = '0;
  int  both_cnt = 0;
  bit  ld_on = 1'b0;
  bit  ld_go0 = 1'b0;
  bit  ld_go1 = 1'b0;
  int  ld_w = 0;
  int  ld_r = 0;
  int  alt = 0;
  sb_t exp0[$];
  sb_t exp1[$];
  gl_t glog[$];

  always #5 up_clk = ~up_clk;

  up_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (ERRD)
  ) dut (
    .up_clk         (up_clk),
    .up_rstn        (up_rstn),
    .m0_wreq        (m0_wreq),
    .m0_waddr       (m0_waddr),
    .m0_wdata       (m0_wdata),
    .m0_wack        (m0_wack),
    .m0_rreq        (m0_rreq),
    .m0_raddr       (m0_raddr),
    .m0_rdata       (m0_rdata),
    .m0_rack        (m0_rack),
    .m1_wreq        (m1_wreq),
    .m1_waddr       (m1_waddr),
    .m1_wdata       (m1_wdata),
    .m1_wack        (m1_wack),
    .m1_rreq        (m1_rreq),
    .m1_raddr       (m1_raddr),
    .m1_rdata       (m1_rdata),
    .m1_rack        (m1_rack),
    .s_wreq         (s_wreq),
    .s_waddr        (s_waddr),
    .s_wdata        (s_wdata),
    .s_wack         (s_wack),
    .s_rreq         (s_rreq),
    .s_raddr        (s_raddr),
    .s_rdata        (s_rdata),
    .s_rack         (s_rack),
    .up_timeout_err (up_timeout_err),
    .up_err_clr     (up_err_clr)
  );

  function automatic logic [31:0] rd_model(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_acks_reqs_err"},
        64'({m0_wack, m0_rack, m1_wack, m1_rack, s_wreq, s_rreq, up_timeout_err}), 64'(0));
    chk({tag, "_addr_wdata"}, 64'({s_waddr, s_raddr, s_wdata}), 64'(0));
    chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'(0));
  endtask

  task automatic push(input int r, input logic rd, input logic [31:0] d, input int c);
    sb_t e;
    e.rd = rd; e.data = d; e.cyc = c;
    if (r == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  task automatic chk_ack(input int r, input logic rd, input logic both, input logic [31:0] rdata);
    sb_t  e;
    logic has;
    int   ec;
    has = (r == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
    checks++;
    assert (has) else begin
      failures++;
      $error("FAIL spurious_ack_m%0d observed=ack_rd%0d expected=no_ack cyc=%0d", r, rd, cyc);
    end
    if (has) begin
      if (r == 0) e = exp0.pop_front();
      else        e = exp1.pop_front();
      ec = (e.cyc < 0) ? cyc : e.cyc;
      checks++;
      assert ({rd, both, (rd ? rdata : 32'h0), 32'(cyc)} === {e.rd, 1'b0, e.data, 32'(ec)}) else begin
        failures++;
        $error("FAIL ack_m%0d observed rd=%0d both=%0d data=%h cyc=%0d expected rd=%0d data=%h cyc=%0d",
               r, rd, both, rdata, cyc, e.rd, e.data, ec);
      end
      if (ld_on) begin
        if (r == 0) ld_go0 = 1'b1;
        else        ld_go1 = 1'b1;
      end
    end
  endtask

  // One clock: clear pulses, run the slave model, log grants and score acks.
  task automatic step();
    gl_t g;
    logic [AW-1:0] a;
    @(posedge up_clk);
    #1;
    cyc++;
    {m0_wreq, m0_rreq, m1_wreq, m1_rreq, up_err_clr} = '0;
    m0_waddr = AW'($urandom); m0_raddr = AW'($urandom);
    m1_waddr = AW'($urandom); m1_raddr = AW'($urandom);
    m0_wdata = $urandom;      m1_wdata = $urandom;
    s_wack = 1'b0; s_rack = 1'b0; s_rdata = $urandom;
    if (!up_rstn) slv_cnt = 0;
    if (slv_cnt > 0) begin
      slv_cnt--;
      if (slv_cnt == 0) begin
        if (slv_rd) begin s_rack = 1'b1; s_rdata = rd_model(slv_addr); end
        else        s_wack = 1'b1;
      end
    end
    if (cyc == frc_wack_cyc) s_wack = 1'b1;
    if (cyc == frc_rack_cyc) begin s_rack = 1'b1; s_rdata = 32'h0BAD_0BAD; end
    if (s_wreq && s_rreq) both_cnt++;
    if (s_wreq || s_rreq) begin
      g.rd = s_rreq; g.addr = s_rreq ? s_raddr : s_waddr; g.data = s_wdata; g.cyc = cyc;
      glog.push_back(g);
      if (slv_delay > 0) begin slv_cnt = slv_delay; slv_rd = g.rd; slv_addr = g.addr; end
    end
    if (ld_on && ld_go0 && ld_w > 0) begin
      m0_wreq = 1'b1; m0_waddr = AW'(14'h200 + ld_w); m0_wdata = 32'h5A00_0000 | 32'(ld_w);
      push(0, 1'b0, 32'h0, -1); ld_w--; ld_go0 = 1'b0;
    end
    if (ld_on && ld_go1 && ld_r > 0) begin
      a = AW'(14'h300 + ld_r);
      m1_rreq = 1'b1; m1_raddr = a;
      push(1, 1'b1, rd_model(a), -1); ld_r--; ld_go1 = 1'b0;
    end
    if (m0_wack || m0_rack) chk_ack(0, m0_rack, m0_wack && m0_rack, m0_rdata);
    if (m1_wack || m1_rack) chk_ack(1, m1_rack, m1_wack && m1_rack, m1_rdata);
  endtask

  initial begin
    logic [63:0] ord;
    up_rstn = 1'b0;
    {m0_wreq, m0_rreq, m1_wreq, m1_rreq, up_err_clr} = '0;
    {m0_waddr, m0_raddr, m1_waddr, m1_raddr} = '0;
    m0_wdata = '0; m1_wdata = '0;
    s_wack = 1'b0; s_rack = 1'b0; s_rdata = '0;
    repeat (3) step();
    chk_zero("reset");
    up_rstn = 1'b1;
    step();

    // Four sources at once straight after reset: ring order S0..S3.
    glog.delete();
    step(); t0 = cyc;
    m0_wreq = 1'b1; m0_waddr = 14'h100; m0_wdata = 32'hA0A0_0001;
    m0_rreq = 1'b1; m0_raddr = 14'h101;
    m1_wreq = 1'b1; m1_waddr = 14'h102; m1_wdata = 32'hB0B0_0002;
    m1_rreq = 1'b1; m1_raddr = 14'h103;
    push(0, 1'b0, 32'h0, t0 + 3);
    push(0, 1'b1, rd_model(14'h101), t0 + 7);
    push(1, 1'b0, 32'h0, t0 + 11);
    push(1, 1'b1, rd_model(14'h103), t0 + 15);
    repeat (18) step();
    chk("four_drained", 64'(exp0.size() + exp1.size()), 64'(0));
    chk("four_count", 64'(glog.size()), 64'(4));
    ord = '0;
    for (int i = 0; i < 4 && i < glog.size(); i++) ord = {ord[49:0], glog[i].addr};
    chk("four_order", ord, 64'({14'h100, 14'h101, 14'h102, 14'h103}));
    if (glog.size() >= 3) chk("four_wdata", {glog[0].data, glog[2].data}, {32'hA0A0_0001, 32'hB0B0_0002});

    // Single write, slave acks one cycle after s_wreq.
    glog.delete();
    step(); t0 = cyc;
    m0_wreq = 1'b1; m0_waddr = 14'h040; m0_wdata = 32'h1234_5678;
    push(0, 1'b0, 32'h0, t0 + 3);
    step();
    chk("single_sreq", 64'({s_wreq, s_rreq, s_waddr, s_wdata}), 64'({1'b1, 1'b0, 14'h040, 32'h1234_5678}));
    repeat (4) step();
    chk("single_drained", 64'(exp0.size()), 64'(0));
    chk("single_err", 64'(up_timeout_err), 64'(0));

    // Sustained load: m0 writes and m1 reads back to back, grants must alternate.
    glog.delete();
    ld_on = 1'b1; ld_go0 = 1'b1; ld_go1 = 1'b1; ld_w = 6; ld_r = 6;
    repeat (80) step();
    ld_on = 1'b0;
    chk("load_drained", 64'(exp0.size() + exp1.size()), 64'(0));
    chk("load_count", 64'(glog.size()), 64'(12));
    alt = 0;
    for (int i = 1; i < glog.size(); i++) if (glog[i].rd != glog[i-1].rd) alt++;
    chk("load_alternation", 64'(alt), 64'(11));

    // Timeout on a read nobody answers, then a late ack that must be dropped.
    slv_delay = 0; glog.delete();
    step(); t0 = cyc;
    m1_rreq = 1'b1; m1_raddr = 14'h3FF;
    push(1, 1'b1, ERRD, t0 + 66);
    frc_rack_cyc = t0 + 70;
    while (cyc < t0 + 66) step();
    chk("tmo_err_set", 64'(up_timeout_err), 64'(2'b10));
    while (cyc < t0 + 74) step();
    chk("tmo_drained", 64'(exp1.size()), 64'(0));
    chk("tmo_rdata_held", 64'(m1_rdata), 64'(ERRD));
    chk("tmo_single_grant", 64'(glog.size()), 64'(1));

    // Write acked exactly on the expiry cycle completes normally.
    frc_rack_cyc = -1;
    step(); t0 = cyc;
    m0_wreq = 1'b1; m0_waddr = 14'h0AA; m0_wdata = 32'h0000_00AA;
    push(0, 1'b0, 32'h0, t0 + 66);
    frc_wack_cyc = t0 + 65;
    while (cyc < t0 + 70) step();
    frc_wack_cyc = -1;
    chk("expiry_drained", 64'(exp0.size()), 64'(0));
    chk("expiry_err_kept", 64'(up_timeout_err), 64'(2'b10));
    up_err_clr = 1'b1;
    step();
    chk("err_clr", 64'(up_timeout_err), 64'(0));

    // Reset while busy with two more requests pending.
    glog.delete();
    step();
    m0_wreq = 1'b1; m0_waddr = 14'h050; m0_wdata = 32'h0000_0050;
    m1_wreq = 1'b1; m1_waddr = 14'h051; m1_wdata = 32'h0000_0051;
    m1_rreq = 1'b1; m1_raddr = 14'h052;
    repeat (3) step();
    chk("mid_busy_grant", 64'(glog.size()), 64'(1));
    #2;
    up_rstn = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (2) step();
    up_rstn = 1'b1;
    glog.delete();
    repeat (6) step();
    chk("post_reset_quiet", 64'(glog.size()), 64'(0));
    slv_delay = 1;
    step(); t0 = cyc;
    m1_rreq = 1'b1; m1_raddr = 14'h123;
    push(1, 1'b1, rd_model(14'h123), t0 + 3);
    repeat (5) step();
    chk("post_reset_drained", 64'(exp0.size() + exp1.size()), 64'(0));
    ord = '0;
    if (glog.size() != 0) ord = 64'({glog[0].rd, glog[0].addr, 32'(glog[0].cyc - t0)});
    chk("post_reset_grant", ord, 64'({1'b1, 14'h123, 32'd1}));
    chk("no_dual_req", 64'(both_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
